// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 block sequencer and its block buffer.
package sha512_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } t_seq_state;

   localparam int SEQ_FIFO_DEPTH = 4;
   localparam int BLOCK_W        = 512;

endpackage

// File: rtl/sha512_block_fifo.sv
// Block buffer between the memory requestor and the hash core; flush empties it but
// a push in the same cycle still lands as the first entry of the emptied buffer.
module sha512_block_fifo
   import sha512_pkg::*;
#(
   parameter int  DEPTH = SEQ_FIFO_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               push,
   input  logic [BLOCK_W-1:0] push_data,
   input  logic               pop,
   output logic [BLOCK_W-1:0] pop_data,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   logic [BLOCK_W-1:0] mem_q [DEPTH];
   logic [BLOCK_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_ok;
   logic               pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Pop is applied before push so a full buffer can accept a block in the cycle it drains one.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop && !empty && !flush;
      push_ok  = push && (flush || !full || pop_ok);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d  = count_d - CNT_W'(1);
      end
      if (push_ok) begin
         mem_d[wr_ptr_d] = push_data;
         wr_ptr_d        = wr_ptr_d + PTR_W'(1);
         count_d         = count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sha512_block_sequencer.sv
// Feeds buffered message blocks to a SHA-512 core one at a time, pulsing init for the
// first block of a job and next for the rest, and returns the digest after the last block.
module sha512_block_sequencer
   import sha512_pkg::*;
#(
   parameter int FIFO_DEPTH = SEQ_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        num_blocks,
   input  logic [BLOCK_W-1:0] block,
   input  logic               block_valid,
   input  logic               core_ready,
   input  logic [BLOCK_W-1:0] core_digest,
   input  logic               core_digest_valid,
   output logic [BLOCK_W-1:0] core_block,
   output logic               core_init,
   output logic               core_next,
   output logic [BLOCK_W-1:0] digest,
   output logic               digest_valid,
   output logic               busy,
   output logic               err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   t_seq_state         state_q, state_d;
   logic [31:0]        num_q, num_d;
   logic [31:0]        issued_q, issued_d;
   logic [BLOCK_W-1:0] core_block_q, core_block_d;
   logic               core_init_q, core_init_d;
   logic               core_next_q, core_next_d;
   logic [BLOCK_W-1:0] digest_q, digest_d;
   logic               digest_valid_q, digest_valid_d;
   logic               err_q, err_d;

   logic               busy_now;
   logic               fifo_flush;
   logic               fifo_push;
   logic               fifo_pop;
   logic [BLOCK_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               unused_fifo_count;

   assign unused_fifo_count = ^fifo_count;
   assign busy_now          = (state_q == S_ISSUE) || (state_q == S_WAIT);

   sha512_block_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (fifo_flush),
      .push     (fifo_push),
      .push_data(block),
      .pop      (fifo_pop),
      .pop_data (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // A start in any state restarts the job; a block arriving with it belongs to the new job.
   always_comb begin
      state_d        = state_q;
      num_d          = num_q;
      issued_d       = issued_q;
      core_block_d   = core_block_q;
      core_init_d    = 1'b0;
      core_next_d    = 1'b0;
      digest_d       = digest_q;
      digest_valid_d = digest_valid_q;
      err_d          = err_q;
      fifo_flush     = 1'b0;
      fifo_pop       = 1'b0;
      fifo_push      = block_valid && (busy_now || (start && (num_blocks != 32'd0)));

      if (start) begin
         num_d          = num_blocks;
         issued_d       = '0;
         fifo_flush     = 1'b1;
         err_d          = 1'b0;
         digest_valid_d = 1'b0;
         state_d        = S_ISSUE;
         if (num_blocks == 32'd0) begin
            digest_d       = '0;
            digest_valid_d = 1'b1;
            err_d          = 1'b1;
            state_d        = S_DONE;
         end
      end else begin
         case (state_q)
            S_ISSUE: begin
               if (!fifo_empty && core_ready) begin
                  fifo_pop     = 1'b1;
                  core_block_d = fifo_head;
                  core_init_d  = (issued_q == 32'd0);
                  core_next_d  = (issued_q != 32'd0);
                  issued_d     = issued_q + 32'd1;
                  state_d      = S_WAIT;
               end
            end
            S_WAIT: begin
               if (core_digest_valid) begin
                  if (issued_q == num_q) begin
                     digest_d       = core_digest;
                     digest_valid_d = 1'b1;
                     state_d        = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                  end
               end
            end
            default: ;
         endcase
      end

      if (block_valid && (!fifo_push || (fifo_full && !fifo_pop && !fifo_flush))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         num_q          <= '0;
         issued_q       <= '0;
         core_block_q   <= '0;
         core_init_q    <= 1'b0;
         core_next_q    <= 1'b0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         num_q          <= num_d;
         issued_q       <= issued_d;
         core_block_q   <= core_block_d;
         core_init_q    <= core_init_d;
         core_next_q    <= core_next_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
         err_q          <= err_d;
      end
   end

   assign core_block   = core_block_q;
   assign core_init    = core_init_q;
   assign core_next    = core_next_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign busy         = busy_now;
   assign err          = err_q;

endmodule

// File: doc/sha512_block_sequencer.md
SHA512_BLOCK_SEQUENCER -- requirements
Module: sha512_block_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning block buffer entries (power of two, >=2).
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  one-cycle pulse beginning a new hash job.
REQ-005 SHALL have num_blocks  input  32  number of 512-bit blocks in the job, sampled on start.
REQ-006 SHALL have block / block_valid  input  512 / 1  message block from the memory requestor; no backpressure.
REQ-007 SHALL have core_ready  input  1  hash core idle and able to accept a block.
REQ-008 SHALL have core_digest / core_digest_valid  input  512 / 1  core result, valid pulse after each processed block.
REQ-009 SHALL have core_block  output  512  block presented to the core.
REQ-010 SHALL have core_init / core_next  output  1 / 1  one-cycle pulses: first block of job / subsequent block.
REQ-011 SHALL have digest / digest_valid  output  512 / 1  final digest to the requestor; valid held as a level.
REQ-012 SHALL have busy  output  1  high in any state other than S_IDLE and S_DONE.
REQ-013 SHALL have err  output  1  sticky error flag.

Function
REQ-014 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_DONE.
REQ-015 S_IDLE/S_DONE + start: latch num_blocks, clear issued counter, flush FIFO, clear err, drop digest_valid -> S_ISSUE; num_blocks==0 -> S_DONE, digest all zeros, digest_valid=1, err=1.
REQ-016 S_ISSUE: FIFO non-empty and core_ready -> pop head, register it onto core_block, next cycle pulse core_init (issued==0) or core_next (issued>0) for exactly one cycle, issued+1 -> S_WAIT.
REQ-017 S_WAIT: on core_digest_valid, issued==latched num_blocks -> latch core_digest into digest, digest_valid=1 next cycle -> S_DONE; else -> S_ISSUE.
REQ-018 core_digest_valid outside S_WAIT SHALL be ignored.
REQ-019 S_DONE: hold digest and digest_valid=1 until next start.
REQ-020 core_block SHALL stay stable between issues; core_init and core_next never high together.
REQ-021 block_valid while busy: write into FIFO; while not busy: drop block, set err.
REQ-022 Full FIFO and block_valid with no pop that cycle: drop block, set err; push and pop in same cycle when full: both succeed.
REQ-023 No bypass: a block written in cycle N is poppable no earlier than cycle N+1.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-025 Issued counter 32 bits, comparison unsigned, full width.
REQ-026 start while busy: abort job, flush FIFO, restart per REQ-015; block_valid in the start cycle SHALL be written into the flushed FIFO.

Reset
REQ-027 Reset SHALL force S_IDLE, FIFO empty, counters 0, core_init=core_next=0, digest_valid=0, digest=0, core_block=0, busy=0, err=0.
REQ-028 Reset mid-job SHALL discard all buffered blocks and any pending digest.

Structure
REQ-029 sha512_pkg SHALL hold t_seq_state enum and SEQ_FIFO_DEPTH default constant.
REQ-030 FIFO SHALL be a sub-module sha512_block_fifo (push, pop, full, empty, count).
REQ-031 FSM, counters and output registers SHALL reside in sha512_block_sequencer.

Verification
REQ-032 start, num_blocks=1, one block A, core_ready=1 -> core_init pulse with core_block=A, no core_next; core digest D -> digest=D, digest_valid=1 one cycle later, busy=0.
REQ-033 num_blocks=3, blocks A,B,C back-to-back -> core_init(A), core_next(B), core_next(C) each after preceding core_digest_valid; digest_valid only after third.
REQ-034 FIFO_DEPTH=4, core_ready=0, six blocks -> four kept, err=1, then core_ready=1 issues first four in order.
REQ-035 start while in S_WAIT with 2 blocks buffered -> FIFO empty, issued=0, next issued block is core_init.
REQ-036 num_blocks=0 -> S_DONE next cycle, digest=0, digest_valid=1, err=1; block_valid in S_DONE keeps err=1 and FIFO empty.
REQ-037 reset asserted mid-job -> all outputs at REQ-027 values immediately, without waiting for clk.
